serial_add_unit: RTL and testbench

- Bit-serial adder stage that consumes operand bit pairs LSB-first, one pair per accepted cycle.
- Produces a registered sum bit stream plus a parallel WIDTH-bit result and final carry.
- Its per-bit combinational core is the half-adder pair (sum = a^b, carry = a&b) chained into a full adder; this block adds the carry register, bit counter and control around it.
- Sits between the tt_um pin mux (ui_in bits) and the uo_out drivers.

---
 rtl/serial_add_pkg.sv | 17 +
 rtl/serial_add_unit_if.sv | 34 +++
 rtl/serial_add_unit_half_cell.sv | 15 +
 rtl/serial_add_unit.sv | 151 +++++++++++++++
 tb/tb_serial_add_unit.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder slice.
//   state_e   : control FSM encoding (IDLE, RUN, DONE)
//   cnt_width : width of the bit counter for a given operand width
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must index bits 0..width-1; keep at least one bit.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_add_unit_if.sv
// Bus bundle between the pin mux / driver side and serial_add_unit.
//   master : drives start, a_bit, b_bit, bit_valid; observes results
//   slave  : the adder itself
//
// Handshake: bit_valid is a one-sided valid with no ready. While the
// adder is busy (RUN) and ena is high, every cycle with bit_valid=1
// consumes exactly one a_bit/b_bit pair; the producer must not present
// more than WIDTH pairs per start. start is a level sampled only in IDLE.
// sum_valid and done are single-cycle pulses; result/carry_out hold
// until the next accepted start.
interface serial_add_unit_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             a_bit;
  logic             b_bit;
  logic             bit_valid;
  logic             busy;
  logic             sum_bit;
  logic             sum_valid;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             done;

  modport master (
    output start, a_bit, b_bit, bit_valid,
    input  busy, sum_bit, sum_valid, result, carry_out, done
  );

  modport slave (
    input  start, a_bit, b_bit, bit_valid,
    output busy, sum_bit, sum_valid, result, carry_out, done
  );
endinterface

// File: rtl/serial_add_unit_half_cell.sv
// Half-adder cell: o_s = i_a ^ i_b, o_c = i_a & i_b.
// Two of these plus an OR form the full adder of serial_add_unit.
//   i_a, i_b : operand bits
//   o_s, o_c : sum and carry
module add_half_cell (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;

endmodule

// File: rtl/serial_add_unit.sv
// Bit-serial adder stage. Consumes operand bit pairs LSB-first, one per
// accepted cycle, emits a registered sum bit stream and assembles the
// WIDTH-bit result plus the final carry.
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   ena         : global enable; low freezes all state (pulses still drop)
//   bus         : serial_add_unit_if slave (start, operand bits, results)
//   o_dbg_state : current FSM state, for observation only
module serial_add_unit
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  serial_add_unit_if.slave    bus,
  output state_e              o_dbg_state
);

  localparam int CW = cnt_width(WIDTH);

  state_e           r_state;
  state_e           w_state_next;
  logic [CW-1:0]    r_count;
  logic             r_carry;
  logic             r_sum_bit;
  logic             r_sum_valid;
  logic             r_busy;
  logic             r_carry_out;
  logic             r_done;
  logic [WIDTH-1:0] r_result;

  logic w_ha0_s;
  logic w_ha0_c;
  logic w_ha1_c;
  logic w_s;
  logic w_c;
  logic w_start;
  logic w_accept;
  logic w_last;
  logic w_finish;

  // Full adder: first cell adds the operand bits, second adds the
  // running carry into that partial sum.
  add_half_cell u_ha0 (
    .i_a (bus.a_bit),
    .i_b (bus.b_bit),
    .o_s (w_ha0_s),
    .o_c (w_ha0_c)
  );

  add_half_cell u_ha1 (
    .i_a (w_ha0_s),
    .i_b (r_carry),
    .o_s (w_s),
    .o_c (w_ha1_c)
  );

  assign w_c = w_ha0_c | w_ha1_c;

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_accept     = 1'b0;
    w_finish     = 1'b0;
    w_last       = (r_count == CW'(WIDTH - 1));
    if (ena) begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            w_start      = 1'b1;
            w_state_next = RUN;
          end
        end
        RUN: begin
          if (bus.bit_valid) begin
            w_accept = 1'b1;
            if (w_last) begin
              w_state_next = DONE;
            end
          end
        end
        DONE: begin
          w_finish     = 1'b1;
          w_state_next = IDLE;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_carry     <= 1'b0;
      r_sum_bit   <= 1'b0;
      r_sum_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_carry_out <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
    end else begin
      // Pulses fall on every edge, independent of ena.
      r_sum_valid <= 1'b0;
      r_done      <= 1'b0;
      if (w_start) begin
        r_carry     <= 1'b0;
        r_count     <= '0;
        r_result    <= '0;
        r_carry_out <= 1'b0;
        r_busy      <= 1'b1;
      end
      if (w_accept) begin
        r_sum_bit   <= w_s;
        r_sum_valid <= 1'b1;
        r_carry     <= w_c;
        // LSB arrives first, so insert at the MSB and shift right.
        r_result    <= {w_s, r_result[WIDTH-1:1]};
        if (w_last) begin
          r_count     <= '0;
          r_carry_out <= w_c;
          r_busy      <= 1'b0;
        end else begin
          r_count <= r_count + CW'(1);
        end
      end
      // done trails the final sum_valid by one cycle.
      if (w_finish) begin
        r_done <= 1'b1;
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.sum_bit   = r_sum_bit;
  assign bus.sum_valid = r_sum_valid;
  assign bus.result    = r_result;
  assign bus.carry_out = r_carry_out;
  assign bus.done      = r_done;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_serial_add_unit.sv
// Self-checking bench for serial_add_unit (WIDTH=8).
module tb_serial_add_unit;
  import serial_add_pkg::*;

  localparam int W = 8;

  logic   clk = 1'b0;
  logic   rst_n;
  logic   ena;
  state_e dbg_state;

  serial_add_unit_if #(.WIDTH(W)) bus ();

  serial_add_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int         checks   = 0;
  int         failures = 0;
  logic [0:0] exp_q[$];
  logic [0:0] exp_bit;
  int         first_sv_cyc;
  int         last_sv_cyc;
  int         done_cyc;
  int         done_cnt;
  logic [W-1:0] done_result;
  logic       done_carry;

  // Reference: the whole addition in one step.
  function automatic logic [W:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b);
    return (W+1)'(a) + (W+1)'(b);
  endfunction

  // Sum-bit stream checked against expected queue; done info captured.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.sum_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sum_valid_extra: pulse at cycle %0d, expected no pulse", cyc);
        end else begin
          exp_bit = exp_q.pop_front();
          if (bus.sum_bit !== exp_bit) begin
            failures++;
            $display("FAIL sum_bit: cycle %0d got %b expected %b", cyc, bus.sum_bit, exp_bit);
          end
        end
        if (first_sv_cyc < 0) first_sv_cyc = cyc;
        last_sv_cyc = cyc;
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_cyc    = cyc;
        done_result = bus.result;
        done_carry  = bus.carry_out;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = model_add(a, b);
    exp_q.delete();
    for (int i = 0; i < W; i++) exp_q.push_back(s[i]);
    done_cnt     = 0;
    first_sv_cyc = -1;
    last_sv_cyc  = -1;
    done_cyc     = -1;
  endtask

  task automatic drive_add(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int gaps[W], input int restart_bit,
                           output int start_cyc);
    clear_obs(a, b);
    bus.start = 1'b1;
    start_cyc = cyc;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < W; i++) begin
      bus.a_bit     = a[i];
      bus.b_bit     = b[i];
      bus.bit_valid = 1'b1;
      bus.start     = (i == restart_bit);
      tick();
      bus.bit_valid = 1'b0;
      bus.start     = 1'b0;
      bus.a_bit     = 1'($urandom_range(0, 1));
      bus.b_bit     = 1'($urandom_range(0, 1));
      repeat (gaps[i]) tick();
    end
  endtask

  task automatic wait_done(output bit timed_out);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 40) begin
      tick();
      n++;
    end
    timed_out = (done_cnt == 0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    ena   = 1'b1;
    bus.start = 1'b0; bus.a_bit = 1'b1; bus.b_bit = 1'b1; bus.bit_valid = 1'b1;
    repeat (3) tick();
    checks++;
    if ({bus.busy, bus.sum_bit, bus.sum_valid, bus.done, bus.carry_out} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 00000",
               {bus.busy, bus.sum_bit, bus.sum_valid, bus.done, bus.carry_out});
    end
    checks++;
    if (bus.result !== '0) begin
      failures++;
      $display("FAIL reset_result: got %h expected 00", bus.result);
    end
    checks++;
    if (dbg_state !== IDLE) begin
      failures++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
    end
    bus.bit_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    // bit_valid in IDLE must not start anything.
    bus.bit_valid = 1'b1;
    repeat (2) tick();
    bus.bit_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.sum_valid !== 1'b0 || dbg_state !== IDLE) begin
      failures++;
      $display("FAIL idle_ignore_valid: got busy=%b sv=%b state=%0d expected 0 0 0",
               bus.busy, bus.sum_valid, dbg_state);
    end
  endtask

  task automatic test_basic();
    int gaps[W];
    int sc;
    bit to;
    logic [W:0] s;
    foreach (gaps[i]) gaps[i] = 0;
    s = model_add(8'h5A, 8'h33);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || dbg_state !== RUN) begin
      failures++;
      $display("FAIL busy_after_start: got busy=%b state=%0d expected 1 1", bus.busy, dbg_state);
    end
    // Leave RUN cleanly: finish the stray start with a dummy-free reset.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    drive_add(8'h5A, 8'h33, gaps, -1, sc);
    wait_done(to);
    checks++;
    if (to) begin failures++; $display("FAIL basic_timeout: got no done expected done"); end
    checks++;
    if (done_cyc - sc !== 10) begin
      failures++; $display("FAIL basic_done_latency: got %0d expected 10", done_cyc - sc);
    end
    checks++;
    if (first_sv_cyc - sc !== 2) begin
      failures++; $display("FAIL basic_first_sv: got %0d expected 2", first_sv_cyc - sc);
    end
    checks++;
    if (done_cyc - last_sv_cyc !== 1) begin
      failures++; $display("FAIL basic_done_after_sv: got %0d expected 1", done_cyc - last_sv_cyc);
    end
    checks++;
    if (done_result !== s[W-1:0] || done_carry !== s[W]) begin
      failures++;
      $display("FAIL basic_result: got %h/%b expected %h/%b", done_result, done_carry, s[W-1:0], s[W]);
    end
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0 || done_cnt != 1) begin
      failures++;
      $display("FAIL basic_counts: got left=%0d done=%0d expected 0 1", exp_q.size(), done_cnt);
    end
    checks++;
    if (bus.busy !== 1'b0 || dbg_state !== IDLE || bus.result !== s[W-1:0]) begin
      failures++;
      $display("FAIL basic_hold: got busy=%b state=%0d res=%h expected 0 0 %h",
               bus.busy, dbg_state, bus.result, s[W-1:0]);
    end
  endtask

  task automatic test_back_to_back();
    int gaps[W];
    int sc;
    bit to;
    logic [W:0] s;
    foreach (gaps[i]) gaps[i] = 0;
    s = model_add(8'hFF, 8'h01);
    drive_add(8'hFF, 8'h01, gaps, -1, sc);
    wait_done(to);
    checks++;
    if (to || done_result !== s[W-1:0] || done_carry !== s[W]) begin
      failures++;
      $display("FAIL b2b_first: got to=%b %h/%b expected 0 %h/%b", to, done_result, done_carry, s[W-1:0], s[W]);
    end
    s = model_add(8'h01, 8'h01);
    drive_add(8'h01, 8'h01, gaps, -1, sc);
    wait_done(to);
    checks++;
    if (to || done_result !== s[W-1:0] || done_carry !== s[W]) begin
      failures++;
      $display("FAIL b2b_second: got to=%b %h/%b expected 0 %h/%b", to, done_result, done_carry, s[W-1:0], s[W]);
    end
    checks++;
    if (done_cyc - sc !== 10 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_latency: got %0d left=%0d expected 10 0", done_cyc - sc, exp_q.size());
    end
  endtask

  task automatic test_gaps();
    int gaps[W];
    int sc;
    bit to;
    logic [W:0] s;
    foreach (gaps[i]) gaps[i] = 0;
    gaps[2] = 3;
    gaps[5] = 1;
    s = model_add(8'h0F, 8'hF1);
    drive_add(8'h0F, 8'hF1, gaps, -1, sc);
    wait_done(to);
    checks++;
    if (to || done_result !== s[W-1:0] || done_carry !== s[W]) begin
      failures++;
      $display("FAIL gaps_result: got to=%b %h/%b expected 0 %h/%b", to, done_result, done_carry, s[W-1:0], s[W]);
    end
    checks++;
    if (done_cyc - sc !== 14 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL gaps_latency: got %0d left=%0d expected 14 0", done_cyc - sc, exp_q.size());
    end
  endtask

  task automatic test_mid_start();
    int gaps[W];
    int sc;
    bit to;
    logic [W:0] s;
    foreach (gaps[i]) gaps[i] = 0;
    s = model_add(8'h12, 8'h34);
    drive_add(8'h12, 8'h34, gaps, 4, sc);
    wait_done(to);
    checks++;
    if (to || done_result !== s[W-1:0] || done_carry !== s[W]) begin
      failures++;
      $display("FAIL mid_start_result: got to=%b %h/%b expected 0 %h/%b", to, done_result, done_carry, s[W-1:0], s[W]);
    end
    repeat (4) tick();
    checks++;
    if (done_cnt != 1 || exp_q.size() != 0 || bus.busy !== 1'b0 || dbg_state !== IDLE) begin
      failures++;
      $display("FAIL mid_start_ignored: got done=%0d left=%0d busy=%b state=%0d expected 1 0 0 0",
               done_cnt, exp_q.size(), bus.busy, dbg_state);
    end
  endtask

  task automatic test_reset_mid_run();
    int gaps[W];
    int sc;
    bit to;
    logic [W:0] s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    a = 8'hAA;
    b = 8'h55;
    clear_obs(a, b);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.a_bit = a[i]; bus.b_bit = b[i]; bus.bit_valid = 1'b1;
      tick();
    end
    bus.bit_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({bus.busy, bus.sum_bit, bus.sum_valid, bus.done, bus.carry_out} !== 5'b0 ||
          bus.result !== '0 || dbg_state !== IDLE) begin
        failures++;
        $display("FAIL reset_mid_run: got flags=%b res=%h state=%0d expected 00000 00 0",
                 {bus.busy, bus.sum_bit, bus.sum_valid, bus.done, bus.carry_out}, bus.result, dbg_state);
      end
      tick();
    end
    exp_q.delete();
    rst_n = 1'b1;
    tick();
    foreach (gaps[i]) gaps[i] = 0;
    s = model_add(8'h03, 8'h05);
    drive_add(8'h03, 8'h05, gaps, -1, sc);
    wait_done(to);
    checks++;
    if (to || done_result !== s[W-1:0] || done_carry !== s[W] || done_cyc - sc !== 10) begin
      failures++;
      $display("FAIL reset_fresh_add: got to=%b %h/%b lat=%0d expected 0 %h/%b 10",
               to, done_result, done_carry, done_cyc - sc, s[W-1:0], s[W]);
    end
  endtask

  task automatic test_ena_freeze();
    logic [W-1:0] ops_a[2];
    logic [W-1:0] ops_b[2];
    logic [W-1:0] snap_res;
    logic         snap_sb;
    logic [W:0]   s;
    int           sc;
    bit           to;
    ops_a[0] = 8'h80; ops_b[0] = 8'h80;
    ops_a[1] = 8'($urandom); ops_b[1] = 8'($urandom);
    for (int k = 0; k < 2; k++) begin
      s = model_add(ops_a[k], ops_b[k]);
      clear_obs(ops_a[k], ops_b[k]);
      bus.start = 1'b1;
      sc = cyc;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < W; i++) begin
        bus.a_bit = ops_a[k][i]; bus.b_bit = ops_b[k][i]; bus.bit_valid = 1'b1;
        if (i == 3) begin
          snap_res  = bus.result;
          snap_sb   = bus.sum_bit;
          ena       = 1'b0;
          bus.start = 1'b1;
          for (int j = 0; j < 5; j++) begin
            tick();
            checks++;
            if (bus.result !== snap_res || bus.sum_bit !== snap_sb || bus.sum_valid !== 1'b0 ||
                bus.busy !== 1'b1 || dbg_state !== RUN) begin
              failures++;
              $display("FAIL ena_freeze: got res=%h sb=%b sv=%b busy=%b state=%0d expected %h %b 0 1 1",
                       bus.result, bus.sum_bit, bus.sum_valid, bus.busy, dbg_state, snap_res, snap_sb);
            end
          end
          ena       = 1'b1;
          bus.start = 1'b0;
        end
        tick();
      end
      bus.bit_valid = 1'b0;
      wait_done(to);
      checks++;
      if (to || done_result !== s[W-1:0] || done_carry !== s[W]) begin
        failures++;
        $display("FAIL ena_result: got to=%b %h/%b expected 0 %h/%b", to, done_result, done_carry, s[W-1:0], s[W]);
      end
      checks++;
      if (done_cyc - sc !== 15 || exp_q.size() != 0) begin
        failures++;
        $display("FAIL ena_latency: got %0d left=%0d expected 15 0", done_cyc - sc, exp_q.size());
      end
    end
  endtask

  task automatic test_random();
    int gaps[W];
    int sc;
    int exp_lat;
    bit to;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0] s;
    for (int n = 0; n < 12; n++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      s = model_add(a, b);
      exp_lat = 10;
      foreach (gaps[i]) begin
        gaps[i] = $urandom_range(0, 2);
        if (i < W - 1) exp_lat += gaps[i];
      end
      drive_add(a, b, gaps, -1, sc);
      wait_done(to);
      checks++;
      if (to || done_result !== s[W-1:0] || done_carry !== s[W]) begin
        failures++;
        $display("FAIL rand_result: %h+%h got to=%b %h/%b expected 0 %h/%b",
                 a, b, to, done_result, done_carry, s[W-1:0], s[W]);
      end
      checks++;
      if (done_cyc - sc !== exp_lat || exp_q.size() != 0) begin
        failures++;
        $display("FAIL rand_latency: got %0d left=%0d expected %0d 0", done_cyc - sc, exp_q.size(), exp_lat);
      end
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    bus.start     = 1'b0;
    bus.a_bit     = 1'b0;
    bus.b_bit     = 1'b0;
    bus.bit_valid = 1'b0;
    rst_n         = 1'b0;
    ena           = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_gaps();
    test_mid_start();
    test_reset_mid_run();
    test_ena_freeze();
    test_random();
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: got time limit expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
